// File: rtl/ram_key_arbiter.sv
// Arbitrates the single-port data RAM between the CPU data port and a FIFO of keyboard writes.
// Optional macro KEY_READ_BYPASS_EN: CPU reads return the youngest pending key write to the same address.
module ram_key_arbiter #(
   parameter int DEPTH    = 4,
   parameter int PTR_W    = 2,
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic [12:0] cpu_addr,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        key_req,
   input  logic [12:0] key_addr,
   input  logic [31:0] key_wdata,
   output logic        key_full,
   output logic [7:0]  key_drop_cnt,
   output logic [12:0] ram_addr,
   output logic        ram_write_enable,
   output logic [31:0] ram_write_data,
   input  logic [31:0] ram_read_data
);

   localparam int CNT_W = PTR_W + 1;

   logic [12:0]      r_fifoAddr [DEPTH];
   logic [31:0]      r_fifoData [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic [7:0]       r_waitCnt;
   logic [7:0]       r_dropCnt;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_keySlot;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_push    = key_req & ~w_full;
   assign w_keySlot = ~w_empty & (~cpu_req | (r_waitCnt == 8'(MAX_WAIT)));

   // Full is judged on the registered count, so a push is refused even when a pop happens in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_waitCnt <= '0;
         r_dropCnt <= '0;
      end else begin
         if (w_push)
            r_wrPtr <= r_wrPtr + 1'b1;
         if (w_keySlot)
            r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_keySlot})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (key_req && w_full && r_dropCnt != 8'hFF)
            r_dropCnt <= r_dropCnt + 1'b1;
         if (w_empty || w_keySlot)
            r_waitCnt <= '0;
         else if (cpu_req && r_waitCnt != 8'(MAX_WAIT))
            r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoAddr[r_wrPtr] <= key_addr;
         r_fifoData[r_wrPtr] <= key_wdata;
      end
   end

   always_comb begin
      ram_addr         = cpu_addr;
      ram_write_enable = cpu_req & cpu_wen;
      ram_write_data   = cpu_wdata;
      cpu_stall        = 1'b0;
      if (w_keySlot) begin
         ram_addr         = r_fifoAddr[r_rdPtr];
         ram_write_enable = 1'b1;
         ram_write_data   = r_fifoData[r_rdPtr];
         cpu_stall        = cpu_req;
      end
   end

`ifdef KEY_READ_BYPASS_EN
   logic [PTR_W-1:0] w_idx;

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      cpu_rdata = ram_read_data;
      w_idx     = '0;
      if (cpu_req && !cpu_wen && !w_keySlot) begin
         for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_fifoAddr[w_idx] == cpu_addr))
               cpu_rdata = r_fifoData[w_idx];
         end
      end
   end
`else
   assign cpu_rdata = ram_read_data;
`endif

   assign key_full     = w_full;
   assign key_drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_ram_key_arbiter.sv
// Self-checking bench for ram_key_arbiter: directed vector table, corner sequences and randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_ram_key_arbiter;

   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 8;

   logic        clk;
   logic        rst_n;
   logic        cpu_req;
   logic [12:0] cpu_addr;
   logic        cpu_wen;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        key_req;
   logic [12:0] key_addr;
   logic [31:0] key_wdata;
   logic        key_full;
   logic [7:0]  key_drop_cnt;
   logic [12:0] ram_addr;
   logic        ram_write_enable;
   logic [31:0] ram_write_data;
   logic [31:0] ram_read_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] tbRam    [2048];
   logic [31:0] modelMem [2048];
   logic [12:0] qAddr [$];
   logic [31:0] qData [$];
   int          mWait;
   int          mDrop;

   typedef struct {
      logic        cpuReq;
      logic [12:0] cpuAddr;
      logic        cpuWen;
      logic [31:0] cpuWdata;
      logic        keyReq;
      logic [12:0] keyAddr;
      logic [31:0] keyWdata;
      logic        expStall;
      logic        expWen;
      logic [12:0] expAddr;
      logic [31:0] expWdata;
   } vec_t;

   vec_t vecs [5];
   logic [12:0] addrSet [4];

   ram_key_arbiter #(.DEPTH(DEPTH), .PTR_W(2), .MAX_WAIT(MAX_WAIT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_req          (cpu_req),
      .cpu_addr         (cpu_addr),
      .cpu_wen          (cpu_wen),
      .cpu_wdata        (cpu_wdata),
      .cpu_rdata        (cpu_rdata),
      .cpu_stall        (cpu_stall),
      .key_req          (key_req),
      .key_addr         (key_addr),
      .key_wdata        (key_wdata),
      .key_full         (key_full),
      .key_drop_cnt     (key_drop_cnt),
      .ram_addr         (ram_addr),
      .ram_write_enable (ram_write_enable),
      .ram_write_data   (ram_write_data),
      .ram_read_data    (ram_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, write on the rising edge, word addressed.
   assign ram_read_data = tbRam[ram_addr[12:2]];
   always @(posedge clk) begin
      if (ram_write_enable)
         tbRam[ram_addr[12:2]] <= ram_write_data;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      qAddr.delete();
      qData.delete();
      mWait = 0;
      mDrop = 0;
   endtask

   // One clock cycle: drive at the falling edge, compare against the model, then advance the model.
   task automatic applyStimulus(input logic cReq, input logic [12:0] cAddr, input logic cWen,
                                input logic [31:0] cWdata, input logic kReq,
                                input logic [12:0] kAddr, input logic [31:0] kData);
      bit          keySlot;
      bit          fullPre;
      logic        expWen;
      logic [12:0] expAddr;
      logic [31:0] expData;
      logic [31:0] expRd;
      @(negedge clk);
      cpu_req   = cReq;
      cpu_addr  = cAddr;
      cpu_wen   = cWen;
      cpu_wdata = cWdata;
      key_req   = kReq;
      key_addr  = kAddr;
      key_wdata = kData;
      #1;
      keySlot = (qAddr.size() > 0) && (!cReq || mWait == MAX_WAIT);
      fullPre = (qAddr.size() == DEPTH);
      expWen  = keySlot ? 1'b1 : (cReq & cWen);
      expAddr = keySlot ? qAddr[0] : cAddr;
      expData = keySlot ? qData[0] : cWdata;
      checkOutput("stall", {31'd0, cpu_stall}, {31'd0, keySlot & cReq});
      checkOutput("ram_wen", {31'd0, ram_write_enable}, {31'd0, expWen});
      checkOutput("ram_addr", {19'd0, ram_addr}, {19'd0, expAddr});
      checkOutput("ram_wdata", ram_write_data, expData);
      checkOutput("key_full", {31'd0, key_full}, {31'd0, fullPre});
      checkOutput("drop_cnt", {24'd0, key_drop_cnt}, mDrop);
      if (cReq && !cWen && !keySlot) begin
         expRd = modelMem[cAddr[12:2]];
`ifdef KEY_READ_BYPASS_EN
         foreach (qAddr[i])
            if (qAddr[i] == cAddr)
               expRd = qData[i];
`endif
         checkOutput("cpu_rdata", cpu_rdata, expRd);
      end
      if (expWen)
         modelMem[expAddr[12:2]] = expData;
      if (keySlot || qAddr.size() == 0)
         mWait = 0;
      else if (cReq && mWait < MAX_WAIT)
         mWait++;
      if (keySlot) begin
         void'(qAddr.pop_front());
         void'(qData.pop_front());
      end
      if (kReq && !fullPre) begin
         qAddr.push_back(kAddr);
         qData.push_back(kData);
      end else if (kReq && mDrop < 255) begin
         mDrop++;
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 13'h0, 1'b0, 32'h0, 1'b0, 13'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         tbRam[i]    = 32'hA500_0000 | i;
         modelMem[i] = 32'hA500_0000 | i;
      end
      addrSet[0] = 13'h310;
      addrSet[1] = 13'h100;
      addrSet[2] = 13'h104;
      addrSet[3] = 13'h200;
      vecs[0] = '{1'b0, 13'h000, 1'b0, 32'h0,    1'b1, 13'h310, 32'h41, 1'b0, 1'b0, 13'h000, 32'h0};
      vecs[1] = '{1'b0, 13'h000, 1'b0, 32'h0,    1'b0, 13'h000, 32'h0,  1'b0, 1'b1, 13'h310, 32'h41};
      vecs[2] = '{1'b1, 13'h100, 1'b1, 32'h1234, 1'b1, 13'h310, 32'h42, 1'b0, 1'b1, 13'h100, 32'h1234};
      vecs[3] = '{1'b0, 13'h000, 1'b0, 32'h0,    1'b0, 13'h000, 32'h0,  1'b0, 1'b1, 13'h310, 32'h42};
      vecs[4] = '{1'b0, 13'h000, 1'b0, 32'h0,    1'b0, 13'h000, 32'h0,  1'b0, 1'b0, 13'h000, 32'h0};

      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_addr  = 13'h0ABC;
      cpu_wen   = 1'b0;
      cpu_wdata = 32'h0;
      key_req   = 1'b0;
      key_addr  = 13'h0;
      key_wdata = 32'h0;
      modelReset();
      #2;
      checkOutput("reset_stall", {31'd0, cpu_stall}, 32'd0);
      checkOutput("reset_full", {31'd0, key_full}, 32'd0);
      checkOutput("reset_drop", {24'd0, key_drop_cnt}, 32'd0);
      checkOutput("reset_wen", {31'd0, ram_write_enable}, 32'd0);
      checkOutput("reset_addr", {19'd0, ram_addr}, 32'h0ABC);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].cpuReq, vecs[i].cpuAddr, vecs[i].cpuWen, vecs[i].cpuWdata,
                       vecs[i].keyReq, vecs[i].keyAddr, vecs[i].keyWdata);
         checkOutput("vec_stall", {31'd0, cpu_stall}, {31'd0, vecs[i].expStall});
         checkOutput("vec_wen", {31'd0, ram_write_enable}, {31'd0, vecs[i].expWen});
         checkOutput("vec_addr", {19'd0, ram_addr}, {19'd0, vecs[i].expAddr});
         checkOutput("vec_wdata", ram_write_data, vecs[i].expWdata);
         if (i == 2)
            checkOutput("ram_word_c4_first", tbRam[11'h0C4], 32'h41);
      end
      checkOutput("ram_word_40", tbRam[11'h040], 32'h1234);
      checkOutput("ram_word_c4", tbRam[11'h0C4], 32'h42);

      // Starvation guard: eight CPU cycles, one forced key slot, then the CPU resumes.
      applyStimulus(1'b1, 13'h100, 1'b0, 32'h0, 1'b1, 13'h310, 32'h55);
      for (int k = 0; k < MAX_WAIT; k++) begin
         applyStimulus(1'b1, 13'h100, 1'b0, 32'h0, 1'b0, 13'h0, 32'h0);
         checkOutput("starve_cpu_served", {31'd0, cpu_stall}, 32'd0);
      end
      applyStimulus(1'b1, 13'h100, 1'b0, 32'h0, 1'b0, 13'h0, 32'h0);
      checkOutput("starve_stall", {31'd0, cpu_stall}, 32'd1);
      checkOutput("starve_wen", {31'd0, ram_write_enable}, 32'd1);
      checkOutput("starve_addr", {19'd0, ram_addr}, 32'h310);
      checkOutput("starve_data", ram_write_data, 32'h55);
      applyStimulus(1'b1, 13'h100, 1'b0, 32'h0, 1'b0, 13'h0, 32'h0);
      checkOutput("starve_resume", {31'd0, cpu_stall}, 32'd0);

      // Overflow: five pushes into a four-entry FIFO, then in-order drain.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 13'h200, 1'b0, 32'h0, 1'b1, 13'h310, 32'h41 + k);
         if (k == 4)
            checkOutput("full_after_4", {31'd0, key_full}, 32'd1);
      end
      applyStimulus(1'b1, 13'h200, 1'b0, 32'h0, 1'b0, 13'h0, 32'h0);
      checkOutput("full_held", {31'd0, key_full}, 32'd1);
      checkOutput("drop_one", {24'd0, key_drop_cnt}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         idleCycle();
         checkOutput("drain_order", ram_write_data, 32'h41 + k);
      end
      idleCycle();
      checkOutput("drained_empty", {31'd0, ram_write_enable}, 32'd0);

      // Read of an address with a pending key write.
      applyStimulus(1'b1, 13'h100, 1'b0, 32'h0, 1'b1, 13'h310, 32'h5A);
      applyStimulus(1'b1, 13'h310, 1'b0, 32'h0, 1'b0, 13'h0, 32'h0);
`ifdef KEY_READ_BYPASS_EN
      checkOutput("bypass_read", cpu_rdata, 32'h5A);
`else
      checkOutput("bypass_read", cpu_rdata, 32'h44);
`endif
      idleCycle();

      // Asynchronous reset with entries pending.
      for (int k = 0; k < 3; k++)
         applyStimulus(1'b1, 13'h300, 1'b0, 32'h0, 1'b1, 13'h310, 32'h61 + k);
      @(negedge clk);
      key_req = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("midreset_full", {31'd0, key_full}, 32'd0);
      checkOutput("midreset_stall", {31'd0, cpu_stall}, 32'd0);
      checkOutput("midreset_wen", {31'd0, ram_write_enable}, 32'd0);
      checkOutput("midreset_drop", {24'd0, key_drop_cnt}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         idleCycle();
         checkOutput("post_reset_no_write", {31'd0, ram_write_enable}, 32'd0);
      end

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(3, 0) != 0), addrSet[$urandom_range(3, 0)],
                       1'($urandom_range(1, 0)), $urandom,
                       ($urandom_range(2, 0) == 0), addrSet[$urandom_range(3, 0)], $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
